// File: rtl/skew_tile_feeder_pkg.sv
// Shared types, default sizes and drain-length helper for the skew tile feeder.
// Optional build macro: SKEW_FEEDER_DBUF_EN (ping-pong tile buffering).
package skew_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam int DEF_LANES = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_BITS  = 8;

    // Number of beats needed to push a full tile through the diagonal skew.
    function automatic int drain_len(input int lanes, input int depth);
        return lanes + depth - 1;
    endfunction

endpackage

// File: rtl/skew_tile_feeder_if.sv
// Tile-in / beat-out bus of the skew tile feeder.
// slave: the feeder itself; master: whoever offers tiles and consumes beats.
interface skew_tile_feeder_if
    import skew_feeder_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    parameter int BITS  = DEF_BITS
);
    logic                in_valid;
    logic                in_ready;
    logic [BITS-1:0]     in_tile [LANES][DEPTH];
    logic                en;
    logic [BITS-1:0]     out_data [LANES];
    logic                out_valid;
    logic                out_last;
    logic                busy;

    modport master (
        output in_valid, in_tile, en,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  in_valid, in_tile, en,
        output in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/skew_tile_feeder_buf.sv
// Whole-tile register with load enable and asynchronous clear.
// Used for the active tile and, when SKEW_FEEDER_DBUF_EN is set, the shadow tile.
module skew_tile_buf
    import skew_feeder_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    parameter int BITS  = DEF_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [BITS-1:0] d [LANES][DEPTH],
    output logic [BITS-1:0] q [LANES][DEPTH]
);
    logic [BITS-1:0] tile_q [LANES][DEPTH];
    logic [BITS-1:0] tile_d [LANES][DEPTH];

    // Next tile: hold unless a load is requested.
    always_comb begin
        // NOTE: the hold value is assigned first so every path drives tile_d and no latch is inferred.
        tile_d = tile_q;
        if (load) begin
            tile_d = d;
        end
    end

    // Tile storage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this is a flop array, not a RAM, so it is cleared on reset; a reset mid-drain must leave no stale tile.
            tile_q <= '{default: '0};
        end else begin
            // NOTE: non-blocking so every flop samples values from before the edge.
            tile_q <= tile_d;
        end
    end

    assign q = tile_q;

endmodule

// File: rtl/skew_tile_feeder.sv
// Accepts a LANES x DEPTH tile in one beat and drains it as a diagonal wavefront:
// lane l lags by l beats, zeros outside the window.
// Optional build macro: SKEW_FEEDER_DBUF_EN adds a shadow tile for gap-free streaming.
module skew_tile_feeder
    import skew_feeder_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    parameter int BITS  = DEF_BITS
) (
    input  logic                clk,
    input  logic                rst,
    skew_tile_feeder_if.slave   bus
);
    localparam int              L      = drain_len(LANES, DEPTH);
    localparam int              TW     = $clog2(DEPTH + LANES);
    localparam int              KW     = $clog2(DEPTH);
    localparam logic [TW-1:0]   T_LAST = TW'(L - 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic            shadow_full_q;
    logic            accept, consume, at_last, draining, load_active;
    logic [BITS-1:0] active_d [LANES][DEPTH];
    logic [BITS-1:0] active_q [LANES][DEPTH];
    logic [BITS-1:0] beat [LANES];

`ifdef SKEW_FEEDER_DBUF_EN
    logic            shadow_full_d, load_shadow, from_shadow;
    logic [BITS-1:0] shadow_q [LANES][DEPTH];

    assign bus.in_ready = !rst && !shadow_full_q;
`else
    assign shadow_full_q = 1'b0;
    assign bus.in_ready  = !rst && (state_q == IDLE);
`endif

    assign draining = (state_q == DRAIN);
    assign accept   = bus.in_valid && bus.in_ready;
    assign consume  = draining && bus.en;
    assign at_last  = (t_q == T_LAST);

    // Next state, beat counter and tile-load decisions.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        load_active = 1'b0;
`ifdef SKEW_FEEDER_DBUF_EN
        shadow_full_d = shadow_full_q;
        load_shadow   = 1'b0;
        from_shadow   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_active = 1'b1;
                    t_d         = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (consume && at_last) begin
                    t_d = '0;
`ifdef SKEW_FEEDER_DBUF_EN
                    if (shadow_full_q) begin
                        load_active   = 1'b1;
                        from_shadow   = 1'b1;
                        shadow_full_d = 1'b0;
                    end else if (accept) begin
                        load_active = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else if (consume) begin
                    t_d = t_q + TW'(1);
                end
`ifdef SKEW_FEEDER_DBUF_EN
                // A tile arriving mid-drain parks in the shadow until the swap.
                if (accept && !(consume && at_last)) begin
                    load_shadow   = 1'b1;
                    shadow_full_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Source of the next active tile: the input bus or the parked shadow tile.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < DEPTH; k++) begin
                active_d[l][k] = bus.in_tile[l][k];
`ifdef SKEW_FEEDER_DBUF_EN
                if (from_shadow) begin
                    active_d[l][k] = shadow_q[l][k];
                end
`endif
            end
        end
    end

    // Skewed beat: lane l shows element t-l when that lies inside the tile.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            beat[l] = '0;
            if (draining && (int'(t_q) >= l) && (int'(t_q) - l < DEPTH)) begin
                beat[l] = active_q[l][KW'(int'(t_q) - l)];
            end
        end
    end

    // FSM state and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    skew_tile_buf #(.LANES(LANES), .DEPTH(DEPTH), .BITS(BITS)) u_active (
        .clk  (clk),
        .rst  (rst),
        .load (load_active),
        .d    (active_d),
        .q    (active_q)
    );

`ifdef SKEW_FEEDER_DBUF_EN
    // Shadow occupancy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_full_q <= 1'b0;
        end else begin
            shadow_full_q <= shadow_full_d;
        end
    end

    skew_tile_buf #(.LANES(LANES), .DEPTH(DEPTH), .BITS(BITS)) u_shadow (
        .clk  (clk),
        .rst  (rst),
        .load (load_shadow),
        .d    (bus.in_tile),
        .q    (shadow_q)
    );
`endif

    assign bus.out_data  = beat;
    assign bus.out_valid = draining;
    assign bus.out_last  = draining && at_last;
    assign bus.busy      = draining || shadow_full_q;

endmodule

// File: tb/tb_skew_tile_feeder.sv
// Directed bench for skew_tile_feeder with LANES=4, DEPTH=4, BITS=8 and A[l][k] = 16*l+k.
// Build with SKEW_FEEDER_DBUF_EN to exercise the ping-pong cases.
module tb_skew_tile_feeder;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int BITS  = 8;

`ifdef SKEW_FEEDER_DBUF_EN
    localparam logic DBUF = 1'b1;
`else
    localparam logic DBUF = 1'b0;
`endif

    // Beats of tile A packed as {lane3, lane2, lane1, lane0}.
    localparam logic [31:0] A_BEATS [7] = '{
        32'h0000_0000, 32'h0000_1001, 32'h0020_1102, 32'h3021_1203,
        32'h3122_1300, 32'h3223_0000, 32'h3300_0000
    };
    // Beats of tile B = A + 0x80 (zeros outside the window stay zero).
    localparam logic [31:0] B_BEATS [7] = '{
        32'h0000_0080, 32'h0000_9081, 32'h00A0_9182, 32'hB0A1_9283,
        32'hB1A2_9300, 32'hB2A3_0000, 32'hB300_0000
    };

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   vcount;

    skew_tile_feeder_if #(.LANES(LANES), .DEPTH(DEPTH), .BITS(BITS)) bus ();

    skew_tile_feeder #(.LANES(LANES), .DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] beat_word();
        return {bus.out_data[3], bus.out_data[2], bus.out_data[1], bus.out_data[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tile(input logic [7:0] offs);
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < DEPTH; k++) begin
                bus.in_tile[l][k] = 8'(16 * l + k) + offs;
            end
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] exp, input logic last);
        check({tag, "_data"}, beat_word(), exp);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_last"}, 32'(bus.out_last), 32'(last));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_last"}, 32'(bus.out_last), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_data"}, beat_word(), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.en       = 1'b0;
        load_tile(8'h00);
        #1;
        // Reset state.
        check_idle("rst");
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(bus.in_ready), 32'd1);
        check_idle("rel");

        // 1. Single tile with en held high.
        load_tile(8'h00);
        bus.in_valid = 1'b1;
        bus.en       = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int b = 0; b < 7; b++) begin
            check_beat($sformatf("t1_b%0d", b), A_BEATS[b], b == 6);
            check($sformatf("t1_busy%0d", b), 32'(bus.busy), 32'd1);
            check($sformatf("t1_rdy%0d", b), 32'(bus.in_ready), 32'(DBUF));
            tick();
        end
        check_idle("t1_end");
        check("t1_end_ready", 32'(bus.in_ready), 32'd1);

        // 2. Stall for three cycles at t=2.
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_beat("t2_b0", A_BEATS[0], 1'b0);
        tick();
        check_beat("t2_b1", A_BEATS[1], 1'b0);
        tick();
        bus.en = 1'b0;
        check_beat("t2_b2", A_BEATS[2], 1'b0);
        for (int s = 0; s < 3; s++) begin
            tick();
            check_beat($sformatf("t2_hold%0d", s), A_BEATS[2], 1'b0);
        end
        bus.en = 1'b1;
        for (int b = 3; b < 7; b++) begin
            tick();
            check_beat($sformatf("t2_b%0d", b), A_BEATS[b], b == 6);
        end
        tick();
        check_idle("t2_end");

`ifndef SKEW_FEEDER_DBUF_EN
        // 4. No ping-pong: a tile offered mid-drain waits for IDLE.
        load_tile(8'h00);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_beat("t4_a0", A_BEATS[0], 1'b0);
        tick();
        load_tile(8'h80);
        bus.in_valid = 1'b1;
        for (int b = 1; b < 7; b++) begin
            check_beat($sformatf("t4_a%0d", b), A_BEATS[b], b == 6);
            check($sformatf("t4_rdy%0d", b), 32'(bus.in_ready), 32'd0);
            tick();
        end
        check("t4_bubble_valid", 32'(bus.out_valid), 32'd0);
        check("t4_bubble_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int b = 0; b < 7; b++) begin
            check_beat($sformatf("t4_b%0d", b), B_BEATS[b], b == 6);
            tick();
        end
        check_idle("t4_end");
`else
        // 3. Ping-pong back-to-back: B loaded at t=1 streams right after A.
        vcount = 0;
        load_tile(8'h00);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int b = 0; b < 7; b++) begin
            check_beat($sformatf("t3_a%0d", b), A_BEATS[b], b == 6);
            check($sformatf("t3_ardy%0d", b), 32'(bus.in_ready), (b < 2) ? 32'd1 : 32'd0);
            if (bus.out_valid) vcount++;
            if (b == 1) begin
                load_tile(8'h80);
                bus.in_valid = 1'b1;
            end
            tick();
            bus.in_valid = 1'b0;
        end
        for (int b = 0; b < 7; b++) begin
            check_beat($sformatf("t3_b%0d", b), B_BEATS[b], b == 6);
            check($sformatf("t3_brdy%0d", b), 32'(bus.in_ready), 32'd1);
            if (bus.out_valid) vcount++;
            tick();
        end
        check("t3_vcount", 32'(vcount), 32'd14);
        check_idle("t3_end");

        // 6. Accept on the same edge as the last consume with shadow empty.
        load_tile(8'h00);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            check_beat($sformatf("t6_a%0d", b), A_BEATS[b], 1'b0);
            tick();
        end
        check_beat("t6_a6", A_BEATS[6], 1'b1);
        load_tile(8'h80);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_beat("t6_b0", B_BEATS[0], 1'b0);
        check("t6_ready", 32'(bus.in_ready), 32'd1);
        check("t6_busy", 32'(bus.busy), 32'd1);
        for (int b = 1; b < 7; b++) begin
            tick();
            check_beat($sformatf("t6_b%0d", b), B_BEATS[b], b == 6);
        end
        tick();
        check_idle("t6_end");
`endif

        // 5. Reset at t=3 (with the shadow loaded when ping-pong is built in).
        load_tile(8'h00);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_beat("t5_b0", A_BEATS[0], 1'b0);
        tick();
        load_tile(8'h80);
        bus.in_valid = DBUF;
        tick();
        bus.in_valid = 1'b0;
        check_beat("t5_b2", A_BEATS[2], 1'b0);
        check("t5_shadow_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check_beat("t5_b3", A_BEATS[3], 1'b0);
        rst = 1'b1;
        #1;
        check_idle("t5_rst");
        check("t5_rst_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_rel_ready", 32'(bus.in_ready), 32'd1);
        for (int s = 0; s < 4; s++) begin
            check_idle($sformatf("t5_post%0d", s));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
